// File: rtl/arb_req_manager.sv
// Requester-side companion to a fixed-priority arbiter: per-port pending counters drive req_o,
// the one-hot grant is consumed and reported, grant legality and per-port starvation are checked.
module arb_req_manager #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned ID_W         = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] push_i,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic                 srv_valid_o,
  output logic [ID_W-1:0]      srv_id_o,
  output logic [NUM_PORTS-1:0] full_o,
  output logic                 drop_o,
  output logic                 err_o,
  output logic [NUM_PORTS-1:0] starve_o,
  input  logic                 clr_err_i
);

  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [7:0]       WaitLimit = 8'(STARVE_LIMIT);
  localparam logic [NUM_PORTS-1:0] GntOne = NUM_PORTS'(1);

  logic [CNT_W-1:0]     cnt_q  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d  [NUM_PORTS];
  logic [7:0]           wait_q [NUM_PORTS];
  logic [7:0]           wait_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] starve_q, starve_d;
  logic [NUM_PORTS-1:0] acc;
  logic                 err_q, err_d;
  logic                 drop_q, drop_d;
  logic                 srv_valid_q, srv_valid_d;
  logic [ID_W-1:0]      srv_id_q, srv_id_d;
  logic                 gnt_any, gnt_onehot, gnt_legal, gnt_illegal;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req_o[i]  = (cnt_q[i] != '0);
      full_o[i] = (cnt_q[i] == CntMax);
    end
  end

  // A grant is accepted only if it is one-hot and lands on a port that is requesting.
  always_comb begin
    gnt_any     = |gnt_i;
    gnt_onehot  = gnt_any && ((gnt_i & (gnt_i - GntOne)) == '0);
    gnt_legal   = gnt_onehot && ((gnt_i & ~req_o) == '0);
    gnt_illegal = gnt_any && !gnt_legal;
    acc         = gnt_legal ? gnt_i : '0;
  end

  always_comb begin
    srv_valid_d = gnt_legal;
    srv_id_d    = srv_id_q;
    drop_d      = 1'b0;
    err_d       = (err_q & ~clr_err_i) | gnt_illegal;
    starve_d    = clr_err_i ? '0 : starve_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i]  = cnt_q[i];
      wait_d[i] = wait_q[i];
      if (push_i[i] && !acc[i]) begin
        if (full_o[i]) drop_d = 1'b1;
        else           cnt_d[i] = cnt_q[i] + CntOne;
      end else if (!push_i[i] && acc[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      if (!req_o[i] || acc[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WaitLimit) begin
        wait_d[i] = wait_q[i] + 8'd1;
      end
      // Set takes priority over a simultaneous clear.
      if (wait_q[i] == WaitLimit) starve_d[i] = 1'b1;
      if (acc[i]) srv_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i]  <= '0;
        wait_q[i] <= '0;
      end
      starve_q    <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      srv_valid_q <= 1'b0;
      srv_id_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wait_q[i] <= wait_d[i];
      end
      starve_q    <= starve_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      srv_valid_q <= srv_valid_d;
      srv_id_q    <= srv_id_d;
    end
  end

  assign srv_valid_o = srv_valid_q;
  assign srv_id_o    = srv_id_q;
  assign drop_o      = drop_q;
  assign err_o       = err_q;
  assign starve_o    = starve_q;

endmodule

// File: doc/arb_req_manager.md
Name: arb_req_manager

Overview:
- Requester-side companion to the team's fixed-priority arbiter (port NUM_PORTS-1 highest).
- Queues pending-request counts per port and drives the arbiter's req vector.
- Consumes the one-hot grant and reports each served port. Also checks grant legality and flags starved ports.
- Sits between the client request sources and the combinational arbiter in the same clock domain.

Parameters:
- NUM_PORTS, 4, number of requesting ports (>=2).
- CNT_W, 3, pending-count width per port. Max pending = 2^CNT_W-1.
- STARVE_LIMIT, 15, consecutive un-granted pending cycles before starve_o asserts. Must be >=1 and <2^8.
- ID_W, $clog2(NUM_PORTS), served-port index width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- push_i  input  NUM_PORTS  per-port request pulse. Each asserted bit adds one pending request that cycle.
- req_o  output  NUM_PORTS  to arbiter. Bit i = (pending_cnt[i] != 0). Combinational from state only.
- gnt_i  input  NUM_PORTS  grant from arbiter, sampled at clk.
- srv_valid_o  output  1  registered. Pulses one cycle after an accepted grant.
- srv_id_o  output  ID_W  registered index of served port, valid with srv_valid_o.
- full_o  output  NUM_PORTS  bit i = pending_cnt[i] at max. Combinational from state.
- drop_o  output  1  registered pulse: at least one push was dropped in the previous cycle.
- err_o  output  1  sticky illegal-grant flag.
- starve_o  output  NUM_PORTS  sticky per-port starvation flag.
- clr_err_i  input  1  synchronous clear of err_o and starve_o.

Behaviour:
- Reset (reset_n low, asynchronous): all pending_cnt=0 and all wait counters=0.
  - Outputs during reset: req_o=0, srv_valid_o=0, srv_id_o=0, full_o=0, drop_o=0, err_o=0, starve_o=0.
  - Deassertion takes effect at the next clk edge.
- Grant acceptance, evaluated each cycle:
  - gnt_i==0: no grant.
  - gnt_i one-hot at bit k with req_o[k]=1: accepted grant to k.
  - Anything else (multi-hot, or a one-hot bit with req_o=0): illegal. No counter changes from the grant. err_o=1 from the next cycle.
- Per-port count update at clk, for port i:
  - push only: +1 if not full; if full, drop.
  - accepted grant only: -1.
  - push and accepted grant in the same cycle: count unchanged, push never dropped (including when full).
  - No wrap-around in either direction.
- drop_o next cycle = OR over ports of (push_i[i] & full_o[i] & no accepted grant to i).
- Served output: on an accepted grant to k, next cycle srv_valid_o=1 and srv_id_o=k. Otherwise srv_valid_o=0 and srv_id_o holds its last value.
  - Latency: push to req_o = 1 cycle. Grant to srv_valid_o = 1 cycle.
- Wait counter per port, 8 bits:
  - Cleared when req_o[i]=0 or on an accepted grant to i.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
  - starve_o[i] sets in the cycle after the counter reaches STARVE_LIMIT and stays set until cleared.
- clr_err_i clears err_o and all starve_o bits at the next edge. If a new error or starve condition occurs in the same cycle, set wins.
- Reset mid-operation discards all pending counts. No srv_valid_o is emitted for them.

Test Plan:
- Directed scenarios use a bench model of the fixed-priority arbiter (port 3 highest) driving gnt_i.
- Reset then push_i=4'b0101 one cycle -> next cycle req_o=0101. Grants go to port 2, then port 0 on consecutive cycles. srv_id_o=2 then 0. Final req_o=0000.
- Push port 1 eight times with gnt_i forced 0 -> count saturates at 7, full_o[1]=1. The eighth push gives drop_o=1 for exactly one cycle.
- With port 1 full, push_i[1]=1 and gnt_i=0010 in the same cycle -> count stays 7, drop_o=0, srv_valid_o=1 with srv_id_o=1.
- gnt_i=0011 with req_o=0011 -> err_o=1 next cycle, counts unchanged. Then gnt_i=1000 with req_o[3]=0 -> err_o stays 1. clr_err_i pulse -> err_o=0.
- Port 3 held pending continuously and port 0 pending with STARVE_LIMIT=15 -> starve_o=0001 after 16 cycles; starve_o[3] stays 0.
- Assert reset_n=0 mid-stream with counts 3/2/1/5 -> all outputs 0 immediately, no srv_valid_o after release.
